// File: rtl/mips_regfile.sv
// 32x32 MIPS general-purpose register file: two combinational read ports, one clocked write port, r0 hardwired to zero.
// Optional write-first read bypass enabled by defining REGFILE_BYPASS_EN.
module mips_regfile #(
    parameter int unsigned       WIDTH   = 32,
    parameter int unsigned       ADDR_W  = 5,
    parameter logic [WIDTH-1:0]  SP_INIT = WIDTH'(32'h0000_3FFC),
    parameter logic [WIDTH-1:0]  GP_INIT = WIDTH'(32'h0000_1800)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic [15:0]       wr_count
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned GP_IDX  = 28;
    localparam int unsigned SP_IDX  = 29;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [15:0]      r_wr_count;
    logic             w_wr_ok;

    // An unknown wr_en evaluates false in the if below, so it never commits.
    assign w_wr_ok = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i == int'(GP_IDX))      r_regs[i] <= GP_INIT;
                else if (i == int'(SP_IDX)) r_regs[i] <= SP_INIT;
                else                        r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Saturating debug counter of writes that actually landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= '0;
        end else if (w_wr_ok && (r_wr_count != CNT_MAX)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign wr_count = r_wr_count;

    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : r_regs[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : r_regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (w_wr_ok && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`else
`endif
    end

endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32-entry, 32-bit general-purpose register file for the Lab3 MIPS CPU.
- Sits directly downstream of the writeback mux4, which selects among ALU result, memory data, PC+4 and LUI immediate.
- Also directly upstream of the ALU operand mux2 (register vs. immediate).
- Two combinational read ports (rs, rt), one clocked write port (rd); register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and port.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- SP_INIT, 32'h0000_3FFC, reset value of register 29 ($sp).
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write enable, sampled on rising clk.
- wr_addr  input  ADDR_W  destination register (rd/rt/31, chosen upstream).
- wr_data  input  WIDTH  write data from the writeback mux4 output.
- rd_addr_a  input  ADDR_W  read port A address (rs).
- rd_addr_b  input  ADDR_W  read port B address (rt).
- rd_data_a  output  WIDTH  read port A data.
- rd_data_b  output  WIDTH  read port B data.
- wr_count  output  16  count of committed non-zero-register writes, saturating; debug only.

Behaviour:
- Reset (rst_n low, asynchronous, no clk needed):
  - All registers clear to 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - wr_count clears to 0.
  - Reset takes priority over a write in the same cycle.
- Reset release: the first write may take effect on the first rising clk edge with rst_n high.
- Write:
  - On rising clk with rst_n high and wr_en high, reg[wr_addr] <= wr_data.
  - Data is visible on read ports after that edge, i.e. one-cycle write-to-read latency.
- Register 0:
  - Writes are silently discarded; reads of address 0 always return 0.
  - A write to reg 0 does not increment wr_count.
- wr_count: increments by 1 on each accepted write to a non-zero register and holds at 16'hFFFF.
- Reads:
  - Purely combinational from the addresses; no clock latency.
  - Both ports may read the same address simultaneously.
- Same-cycle read/write of the same address: the read returns the old value until the edge, unless REGFILE_BYPASS_EN is defined.
- Reset mid-operation: any pending write in that cycle is lost; read ports immediately reflect the reset values.
- X handling: wr_addr/wr_data are ignored when wr_en is low; an unknown value on wr_en must not corrupt registers in simulation (treat as no write).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wr_en is high, wr_addr != 0 and wr_addr equals a read address, that read port returns wr_data combinationally in the same cycle (write-first).
- Not defined: read-old behaviour; the new value appears only after the clock edge.
- Register 0 always reads 0 in both builds.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> reg1 reads 0, reg28 reads 32'h1800, reg29 reads 32'h3FFC, wr_count=0, all without a clock edge.
- Basic write/read: write 32'hDEADBEEF to reg 5 -> rd_data_a(5) shows it the cycle after; the same cycle shows the old value 0 (bypass off).
- Zero register: write 32'hFFFFFFFF to reg 0 -> both ports read 0 at address 0; wr_count unchanged.
- Dual-port read: load reg 31 = 32'h00400008 and reg 2 = 32'h7 -> rd_addr_a=31, rd_addr_b=2 return both concurrently; rd_addr_a=rd_addr_b=2 returns 32'h7 on both.
- Bypass build: with REGFILE_BYPASS_EN, write reg 8 = 32'h12345678 while reading reg 8 -> rd_data_a = 32'h12345678 in the same cycle; reg 0 still reads 0.
- Reset mid-write: wr_en=1 to reg 9 = 32'hA5A5A5A5 with rst_n dropping before the edge -> reg 9 reads 0 after reset; write 70000 times to reg 3 -> wr_count = 16'hFFFF.
